// File: rtl/store_data_forward_tracker.sv
// store_data_forward_tracker
//
// Tracks the last DEPTH producers that have left stage 3 and picks the youngest one
// whose rd matches the rs2 of a store currently in stage 3. That producer supplies the
// store data. If it is a load still in stage 4 and its data has not arrived yet, the
// unit stalls instead. It also keeps a saturating count of forwards actually consumed.
//
// Ports:
//   CLK, RESET          clock; synchronous active-high reset
//   PIPE_ADVANCE        pipeline shifts one stage this cycle
//   FLUSH               drop all history (branch/jump flush)
//   PRODUCER_*          rd / write-enable / is-load of the instruction leaving stage 3
//   CONSUMER_REG_ADDR2  rs2 of the stage-3 instruction
//   CONSUMER_MEM_WRITE  stage-3 instruction is a store
//   LOAD_DATA_VALID     stage-4 load data is available this cycle
//   FWD_SEL             0 = no forward, k = forward from history slot k-1
//   FWD_VALID           forwarding active this cycle
//   STALL               store data not yet available; hold stage 3 and earlier
//   FWD_COUNT           saturating count of consumed forwards

module store_data_forward_tracker #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PIPE_ADVANCE,
    input  logic              FLUSH,
    input  logic [ADDR_W-1:0] PRODUCER_REG_ADDR,
    input  logic              PRODUCER_WRITE_EN,
    input  logic              PRODUCER_IS_LOAD,
    input  logic [ADDR_W-1:0] CONSUMER_REG_ADDR2,
    input  logic              CONSUMER_MEM_WRITE,
    input  logic              LOAD_DATA_VALID,
    output logic [SEL_W-1:0]  FWD_SEL,
    output logic              FWD_VALID,
    output logic              STALL,
    output logic [CNT_W-1:0]  FWD_COUNT
);

    // Slot 0 is the youngest producer (now in stage 4).
    logic [DEPTH-1:0]  slot_valid_q;
    logic [ADDR_W-1:0] slot_addr_q [DEPTH];
    logic [DEPTH-1:0]  slot_load_q;
    logic [CNT_W-1:0]  fwd_count_q;

    logic [DEPTH-1:0]  hit;
    logic              found;
    logic [SEL_W-1:0]  win_sel;
    logic              win_pending;

    // History shift register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            slot_valid_q <= '0;
            slot_load_q  <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                slot_addr_q[k] <= '0;
            end
        end else if (FLUSH) begin
            // Flush wins over advance: the incoming producer is dropped too.
            slot_valid_q <= '0;
        end else if (PIPE_ADVANCE) begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                slot_valid_q[k] <= slot_valid_q[k-1];
                slot_addr_q[k]  <= slot_addr_q[k-1];
                slot_load_q[k]  <= slot_load_q[k-1];
            end
            // Writes to x0 never produce forwardable data.
            slot_valid_q[0] <= PRODUCER_WRITE_EN && (PRODUCER_REG_ADDR != '0);
            slot_addr_q[0]  <= PRODUCER_REG_ADDR;
            slot_load_q[0]  <= PRODUCER_IS_LOAD;
        end
    end

    // Forward event counter, saturating.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fwd_count_q <= '0;
        end else if (!FLUSH && PIPE_ADVANCE && FWD_VALID && (fwd_count_q != '1)) begin
            fwd_count_q <= fwd_count_q + 1'b1;
        end
    end

    // Youngest-match selection.
    always_comb begin
        hit         = '0;
        found       = 1'b0;
        win_sel     = '0;
        win_pending = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            hit[k] = CONSUMER_MEM_WRITE && slot_valid_q[k] &&
                     (slot_addr_q[k] == CONSUMER_REG_ADDR2) && (CONSUMER_REG_ADDR2 != '0);
            if (hit[k] && !found) begin
                found   = 1'b1;
                win_sel = SEL_W'(k + 1);
                // Only the stage-4 slot can still be waiting on memory; older loads
                // have already captured their data.
                win_pending = (k == 0) && slot_load_q[0] && !LOAD_DATA_VALID;
            end
        end
    end

    always_comb begin
        FWD_SEL   = '0;
        FWD_VALID = 1'b0;
        STALL     = 1'b0;
        if (!RESET && found) begin
            FWD_SEL   = win_sel;
            FWD_VALID = !win_pending;
            STALL     = win_pending;
        end
    end

    assign FWD_COUNT = fwd_count_q;

endmodule

// File: tb/tb_store_data_forward_tracker.sv
// Testbench for store_data_forward_tracker: directed steps followed by random traffic,
// all checked against a queue-based reference model of the producer history.

module tb_store_data_forward_tracker;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              PIPE_ADVANCE;
    logic              FLUSH;
    logic [ADDR_W-1:0] PRODUCER_REG_ADDR;
    logic              PRODUCER_WRITE_EN;
    logic              PRODUCER_IS_LOAD;
    logic [ADDR_W-1:0] CONSUMER_REG_ADDR2;
    logic              CONSUMER_MEM_WRITE;
    logic              LOAD_DATA_VALID;
    logic [SEL_W-1:0]  FWD_SEL;
    logic              FWD_VALID;
    logic              STALL;
    logic [CNT_W-1:0]  FWD_COUNT;

    always #5 CLK = ~CLK;

    store_data_forward_tracker #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .PIPE_ADVANCE       (PIPE_ADVANCE),
        .FLUSH              (FLUSH),
        .PRODUCER_REG_ADDR  (PRODUCER_REG_ADDR),
        .PRODUCER_WRITE_EN  (PRODUCER_WRITE_EN),
        .PRODUCER_IS_LOAD   (PRODUCER_IS_LOAD),
        .CONSUMER_REG_ADDR2 (CONSUMER_REG_ADDR2),
        .CONSUMER_MEM_WRITE (CONSUMER_MEM_WRITE),
        .LOAD_DATA_VALID    (LOAD_DATA_VALID),
        .FWD_SEL            (FWD_SEL),
        .FWD_VALID          (FWD_VALID),
        .STALL              (STALL),
        .FWD_COUNT          (FWD_COUNT)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a list of producer records, youngest first.
    typedef struct {
        bit          wr;
        int unsigned rd;
        bit          ld;
    } prod_t;

    prod_t       hist[$];
    int unsigned m_cnt;
    int unsigned e_sel;
    bit          e_val;
    bit          e_stall;

    function automatic void model_eval();
        bit done;
        done    = 1'b0;
        e_sel   = 0;
        e_val   = 1'b0;
        e_stall = 1'b0;
        if (!RESET && CONSUMER_MEM_WRITE && (CONSUMER_REG_ADDR2 != 0)) begin
            for (int i = 0; i < hist.size(); i++) begin
                if (!done && hist[i].wr && (hist[i].rd != 0) &&
                    (hist[i].rd == int'(CONSUMER_REG_ADDR2))) begin
                    done = 1'b1;
                    if (i == 0 && hist[i].ld && !LOAD_DATA_VALID) begin
                        e_stall = 1'b1;
                        e_sel   = 1;
                    end else begin
                        e_val = 1'b1;
                        e_sel = i + 1;
                    end
                end
            end
        end
    endfunction

    function automatic void model_edge();
        prod_t p;
        model_eval();
        if (RESET) begin
            hist.delete();
            m_cnt = 0;
        end else if (FLUSH) begin
            hist.delete();
        end else if (PIPE_ADVANCE) begin
            if (e_val && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            p.wr = PRODUCER_WRITE_EN;
            p.rd = int'(PRODUCER_REG_ADDR);
            p.ld = PRODUCER_IS_LOAD;
            hist.push_front(p);
            if (hist.size() > int'(DEPTH)) void'(hist.pop_back());
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        model_eval();
        chk({tag, ".sel"},   32'(FWD_SEL),   32'(e_sel));
        chk({tag, ".valid"}, 32'(FWD_VALID), 32'(e_val));
        chk({tag, ".stall"}, 32'(STALL),     32'(e_stall));
        chk({tag, ".count"}, 32'(FWD_COUNT), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic drive(input bit adv, input bit fl, input int unsigned rd, input bit we,
                         input bit ld, input int unsigned rs2, input bit st, input bit ldv);
        PIPE_ADVANCE       = adv;
        FLUSH              = fl;
        PRODUCER_REG_ADDR  = ADDR_W'(rd);
        PRODUCER_WRITE_EN  = we;
        PRODUCER_IS_LOAD   = ld;
        CONSUMER_REG_ADDR2 = ADDR_W'(rs2);
        CONSUMER_MEM_WRITE = st;
        LOAD_DATA_VALID    = ldv;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        hist.delete();
        m_cnt = 0;

        // Reset with an active store on rs2=5.
        RESET = 1'b1;
        drive(1, 0, 5, 1, 0, 5, 1, 0);
        tick();
        check_all("reset1");
        tick();
        check_all("reset2");
        RESET = 1'b0;

        // Single ALU producer ageing through the history.
        drive(1, 0, 5, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 5, 1, 0);
        check_all("age_s0");
        chk("age_s0_const", 32'(FWD_SEL), 32'd1);
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        check_all("age_adv1");
        tick();
        check_all("age_s1");
        tick();
        check_all("age_s2");
        chk("age_s2_const", 32'(FWD_SEL), 32'd3);
        tick();
        check_all("age_gone");
        chk("age_gone_const", 32'(FWD_VALID), 32'd0);

        // Youngest of two matches wins; x0 never forwards.
        drive(1, 0, 7, 1, 0, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 7, 1, 0);
        check_all("youngest");
        chk("youngest_const", 32'(FWD_SEL), 32'd1);
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check_all("x0");
        chk("x0_const", 32'(FWD_VALID), 32'd0);

        // Pending load in stage 4 stalls until its data arrives.
        drive(1, 0, 9, 1, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 9, 1, 0);
        for (int i = 0; i < 3; i++) begin
            check_all("ld_wait");
            chk("ld_wait_stall", 32'(STALL), 32'd1);
            tick();
        end
        LOAD_DATA_VALID = 1'b1;
        check_all("ld_ready");
        chk("ld_ready_valid", 32'(FWD_VALID), 32'd1);

        // Flush beats advance; the producer alongside it is not captured.
        drive(1, 0, 4, 1, 0, 0, 0, 0);
        tick();
        drive(1, 1, 4, 1, 0, 4, 1, 0);
        check_all("flush_pre");
        tick();
        drive(0, 0, 0, 0, 0, 4, 1, 0);
        check_all("flush_post");
        chk("flush_post_const", 32'(FWD_VALID), 32'd0);

        // Counter saturation.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 21; i++) begin
            drive(1, 0, 3, 1, 0, 3, 1, 1);
            check_all("sat");
            tick();
        end
        check_all("sat_end");
        chk("sat_const", 32'(FWD_COUNT), 32'(CNT_MAX));

        // Random traffic on a small register range to provoke plenty of matches.
        for (int i = 0; i < 500; i++) begin
            RESET = ($urandom_range(0, 99) < 3);
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 3), $urandom_range(0, 99) < 80, $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 99) < 75, $urandom_range(0, 1));
            check_all("rand");
            tick();
        end
        RESET = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
